// File: rtl/ysyx_23060077_jump_resolve.sv
// Jump resolver: holds fetch while a jump-class instruction is in flight, then
// computes the next PC once the EXU resolves it and hands it back to the IFU.
module ysyx_23060077_jump_resolve #(
    parameter int ADDR_WIDTH = 32,
    parameter int PC_STEP    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ifu_jump_fire,
    output logic                  ifu_stall,
    input  logic                  exu_valid,
    input  logic                  exu_branch,
    input  logic                  exu_jal,
    input  logic                  exu_jalr,
    input  logic                  exu_ecall,
    input  logic                  exu_mret,
    input  logic                  exu_br_taken,
    input  logic [ADDR_WIDTH-1:0] exu_pc,
    input  logic [ADDR_WIDTH-1:0] exu_imm,
    input  logic [ADDR_WIDTH-1:0] exu_rs1,
    input  logic [ADDR_WIDTH-1:0] csr_mtvec,
    input  logic [ADDR_WIDTH-1:0] csr_mepc,
    output logic                  redirect_valid,
    input  logic                  redirect_ready,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  redirect_misalign,
    output logic [31:0]           jump_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   target_q;
    logic                    misalign_q;
    logic [31:0]             jump_cnt_q;
    logic [ADDR_WIDTH-1:0]   target;
    logic [ADDR_WIDTH-1:0]   jalr_sum;
    logic                    is_jump;
    logic                    resolve;
    logic                    redirect_fire;

    // Non-jump EXU beats seen in WAIT are older instructions draining out.
    assign is_jump       = exu_branch | exu_jal | exu_jalr | exu_ecall | exu_mret;
    assign resolve       = (state_q == WAIT) & exu_valid & is_jump;
    assign redirect_fire = (state_q == RESP) & redirect_ready;
    assign jalr_sum      = exu_rs1 + exu_imm;

    always_comb begin
        target = exu_pc + ADDR_WIDTH'(PC_STEP);
        if (exu_ecall) begin
            target = csr_mtvec;
        end else if (exu_mret) begin
            target = csr_mepc;
        end else if (exu_jalr) begin
            target = {jalr_sum[ADDR_WIDTH-1:1], 1'b0};
        end else if (exu_jal || (exu_branch && exu_br_taken)) begin
            target = exu_pc + exu_imm;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ifu_jump_fire) state_d = WAIT;
            WAIT:    if (resolve)       state_d = RESP;
            RESP:    if (redirect_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            target_q   <= '0;
            misalign_q <= 1'b0;
            jump_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (resolve) begin
                target_q   <= target;
                misalign_q <= |target[1:0];
            end
            if (redirect_fire) begin
                jump_cnt_q <= jump_cnt_q + 32'd1;
            end
        end
    end

    assign ifu_stall         = (state_q != IDLE) | ifu_jump_fire;
    assign redirect_valid    = (state_q == RESP);
    assign redirect_pc       = target_q;
    assign redirect_misalign = misalign_q;
    assign jump_cnt          = jump_cnt_q;

endmodule

// File: tb/tb_ysyx_23060077_jump_resolve.sv
// Bench for the jump resolver: a vector table of jump classes plus hand-built
// sequences for stalls, draining beats, mid-redirect reset and counter wrap.
module tb_ysyx_23060077_jump_resolve;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_jump_fire;
    logic        ifu_stall;
    logic        exu_valid;
    logic        exu_branch, exu_jal, exu_jalr, exu_ecall, exu_mret;
    logic        exu_br_taken;
    logic [31:0] exu_pc, exu_imm, exu_rs1, csr_mtvec, csr_mepc;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;
    logic        redirect_misalign;
    logic [31:0] jump_cnt;

    ysyx_23060077_jump_resolve #(.ADDR_WIDTH(32), .PC_STEP(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .ifu_jump_fire     (ifu_jump_fire),
        .ifu_stall         (ifu_stall),
        .exu_valid         (exu_valid),
        .exu_branch        (exu_branch),
        .exu_jal           (exu_jal),
        .exu_jalr          (exu_jalr),
        .exu_ecall         (exu_ecall),
        .exu_mret          (exu_mret),
        .exu_br_taken      (exu_br_taken),
        .exu_pc            (exu_pc),
        .exu_imm           (exu_imm),
        .exu_rs1           (exu_rs1),
        .csr_mtvec         (csr_mtvec),
        .csr_mepc          (csr_mepc),
        .redirect_valid    (redirect_valid),
        .redirect_ready    (redirect_ready),
        .redirect_pc       (redirect_pc),
        .redirect_misalign (redirect_misalign),
        .jump_cnt          (jump_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        br, jal, jalr, ecall, mret, taken;
        logic [31:0] pc, imm, rs1, mtvec, mepc;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    vec_t        vecs[9];
    logic [32:0] exp_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_cnt = 32'd0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_exu();
        exu_valid = 0; exu_branch = 0; exu_jal = 0; exu_jalr = 0;
        exu_ecall = 0; exu_mret = 0; exu_br_taken = 0;
    endtask

    // Issue a jump, resolve it on the very next cycle and queue the expected redirect.
    task automatic apply_stimulus(input vec_t v);
        ifu_jump_fire = 1;
        tick();
        ifu_jump_fire = 0;
        exu_valid = 1; exu_branch = v.br; exu_jal = v.jal; exu_jalr = v.jalr;
        exu_ecall = v.ecall; exu_mret = v.mret; exu_br_taken = v.taken;
        exu_pc = v.pc; exu_imm = v.imm; exu_rs1 = v.rs1;
        csr_mtvec = v.mtvec; csr_mepc = v.mepc;
        exp_q.push_back({v.exp_mis, v.exp_pc});
        tick();
        clear_exu();
        #1;
        check_output({v.name, " latency"}, 64'(redirect_valid), 64'd1);
    endtask

    // Wait (bounded) for a redirect and compare it against the scoreboard head.
    task automatic check_redirect(input string name);
        logic [32:0] exp;
        int          n = 0;
        while (!redirect_valid && n < 10) begin
            tick();
            n++;
        end
        if (!redirect_valid) check_output({name, " timeout"}, 64'(redirect_valid), 64'd1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check_output({name, " pc"}, 64'(redirect_pc), 64'(exp[31:0]));
            check_output({name, " misalign"}, 64'(redirect_misalign), 64'(exp[32]));
        end
    endtask

    task automatic complete_redirect(input string name);
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
        exp_cnt = exp_cnt + 32'd1;
        #1;
        check_output({name, " idle"}, 64'(redirect_valid), 64'd0);
        check_output({name, " stall"}, 64'(ifu_stall), 64'd0);
        check_output({name, " cnt"}, 64'(jump_cnt), 64'(exp_cnt));
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
        exp_cnt = 0;
        exp_q.delete();
        #1;
    endtask

    initial begin
        //          name       br jal jalr ec mr tk  pc            imm           rs1           mtvec         mepc          exp_pc        mis
        vecs[0] = '{"br_taken", 1, 0, 0, 0, 0, 1, 32'h3000_0010, 32'hFFFF_FFF0, 32'h0,        32'h0,        32'h0,        32'h3000_0000, 0};
        vecs[1] = '{"br_not",   1, 0, 0, 0, 0, 0, 32'h3000_0010, 32'hFFFF_FFF0, 32'h0,        32'h0,        32'h0,        32'h3000_0014, 0};
        vecs[2] = '{"jalr_mis", 0, 0, 1, 0, 0, 0, 32'h0000_1000, 32'h0,         32'h8000_0003, 32'h0,        32'h0,        32'h8000_0002, 1};
        vecs[3] = '{"jal_mis",  0, 1, 0, 0, 0, 0, 32'h0000_1000, 32'h0000_07FE, 32'h0,        32'h0,        32'h0,        32'h0000_17FE, 1};
        vecs[4] = '{"jalr_clr", 0, 0, 1, 0, 0, 1, 32'h0000_1000, 32'h0000_0101, 32'h2000_0000, 32'h0,        32'h0,        32'h2000_0100, 0};
        vecs[5] = '{"ecall",    0, 0, 0, 1, 0, 0, 32'h0000_1000, 32'h0000_0040, 32'h0,        32'h8000_0100, 32'h1234_5678, 32'h8000_0100, 0};
        vecs[6] = '{"mret_mis", 0, 0, 0, 0, 1, 0, 32'h0000_1000, 32'h0000_0040, 32'h0,        32'h8000_0100, 32'h3000_0202, 32'h3000_0202, 1};
        vecs[7] = '{"jal_wrap", 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0,        32'h0,        32'h0,        32'h0000_0004, 0};
        vecs[8] = '{"br_wrap",  1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0000_0100, 32'h0,        32'h0,        32'h0,        32'h0000_0000, 0};

        ifu_jump_fire = 0; redirect_ready = 0;
        exu_pc = 0; exu_imm = 0; exu_rs1 = 0; csr_mtvec = 0; csr_mepc = 0;
        clear_exu();
        do_reset();

        check_output("reset valid", 64'(redirect_valid), 64'd0);
        check_output("reset cnt", 64'(jump_cnt), 64'd0);
        check_output("reset stall", 64'(ifu_stall), 64'd0);
        check_output("reset pc", 64'(redirect_pc), 64'd0);
        check_output("reset mis", 64'(redirect_misalign), 64'd0);
        ifu_jump_fire = 1;
        #1;
        check_output("stall comb", 64'(ifu_stall), 64'd1);
        tick();
        ifu_jump_fire = 0;
        #1;
        check_output("stall held", 64'(ifu_stall), 64'd1);
        check_output("wait no valid", 64'(redirect_valid), 64'd0);
        do_reset();

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i]);
            check_redirect(vecs[i].name);
            complete_redirect(vecs[i].name);
        end

        // ecall target must survive later mtvec changes while the IFU holds off.
        do_reset();
        apply_stimulus(vecs[5]);
        check_redirect("ecall_hold");
        csr_mtvec = 32'hDEAD_BEEC;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("hold valid", 64'(redirect_valid), 64'd1);
            check_output("hold pc", 64'(redirect_pc), 64'h8000_0100);
        end
        complete_redirect("ecall_hold");

        // Back-to-back: new jump right after the redirect fires; drain beats then mret.
        ifu_jump_fire = 1;
        #1;
        check_output("b2b stall", 64'(ifu_stall), 64'd1);
        tick();
        ifu_jump_fire = 0;
        for (int i = 0; i < 3; i++) begin
            exu_valid = 1;
            exu_pc = 32'h0000_4000 + 32'(i * 4);
            csr_mepc = 32'h0BAD_0000;
            tick();
            check_output("drain no valid", 64'(redirect_valid), 64'd0);
            check_output("drain stall", 64'(ifu_stall), 64'd1);
        end
        exu_mret = 1; csr_mepc = 32'h3000_0200;
        exp_q.push_back({1'b0, 32'h3000_0200});
        tick();
        clear_exu();
        check_redirect("mret_drain");
        ifu_jump_fire = 1;
        tick();
        ifu_jump_fire = 0;
        #1;
        check_output("resp fire ignored", 64'(redirect_valid), 64'd1);
        check_output("resp fire pc", 64'(redirect_pc), 64'h3000_0200);
        complete_redirect("mret_drain");
        tick();
        tick();
        check_output("no second jump", 64'(redirect_valid), 64'd0);
        check_output("no second stall", 64'(ifu_stall), 64'd0);

        // Reset while a redirect is pending.
        apply_stimulus(vecs[0]);
        reset = 1;
        tick();
        reset = 0;
        exp_cnt = 0;
        exp_q.delete();
        #1;
        check_output("rst_resp valid", 64'(redirect_valid), 64'd0);
        check_output("rst_resp cnt", 64'(jump_cnt), 64'd0);
        check_output("rst_resp stall", 64'(ifu_stall), 64'd0);

        // Counter wrap from all-ones.
        force dut.jump_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.jump_cnt_q;
        #1;
        check_output("preload cnt", 64'(jump_cnt), 64'hFFFF_FFFF);
        exp_cnt = 32'hFFFF_FFFF;
        apply_stimulus(vecs[3]);
        check_redirect("wrap");
        complete_redirect("wrap");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ysyx_23060077_jump_resolve.md
# ysyx_23060077_jump_resolve

Closes the control-flow loop opened by the IFU pre-decoder. When the IFU issues a jump-class instruction (branch, jal, jalr, ecall, mret), fetch stalls. This block waits for the EXU to resolve that instruction, computes the next PC, and returns it to the IFU over a valid/ready redirect handshake. Exactly one jump is outstanding at a time. The block sits between the EXU/CSR outputs and the IFU PC-update logic.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC/target width
- PC_STEP, 4, sequential-PC increment

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- ifu_jump_fire  in  1  IFU handed a jump-class instruction downstream this cycle
- ifu_stall  out  1  IFU must not fetch a new instruction
- exu_valid  in  1  EXU result valid this cycle
- exu_branch, exu_jal, exu_jalr, exu_ecall, exu_mret  in  1 each  decoded class of the EXU instruction; at most one is set
- exu_br_taken  in  1  branch comparison result
- exu_pc  in  ADDR_WIDTH  PC of the EXU instruction
- exu_imm  in  ADDR_WIDTH  sign-extended immediate
- exu_rs1  in  ADDR_WIDTH  rs1 operand (jalr base)
- csr_mtvec, csr_mepc  in  ADDR_WIDTH  current CSR values
- redirect_valid  out  1  redirect_pc is valid
- redirect_ready  in  1  IFU accepts the redirect
- redirect_pc  out  ADDR_WIDTH  next fetch PC
- redirect_misalign  out  1  target bits [1:0] are nonzero; held with redirect_valid
- jump_cnt  out  32  count of completed redirects, wraps

## Operation
- States:
  - IDLE: no jump outstanding
  - WAIT: jump issued, not yet resolved
  - RESP: redirect pending
- IDLE → WAIT on ifu_jump_fire.
- WAIT → RESP on exu_valid with any class bit set. On this transition the block registers the target and misalign flag.
- A WAIT cycle with exu_valid and no class bit set is an older non-jump instruction draining. Ignore it and stay in WAIT.
- RESP → IDLE on redirect_valid & redirect_ready. jump_cnt increments by 1 on the same edge, wrapping 0xFFFF_FFFF → 0.
- ifu_jump_fire in WAIT or RESP is a protocol violation. Ignore it: no state change, no second pending jump.
- Target selection, all arithmetic modulo 2^ADDR_WIDTH:
  - branch taken: exu_pc + exu_imm
  - branch not taken: exu_pc + PC_STEP
  - jal: exu_pc + exu_imm
  - jalr: (exu_rs1 + exu_imm) with bit 0 cleared
  - ecall: csr_mtvec
  - mret: csr_mepc
- redirect_misalign = registered (target[1:0] != 0). It is computed after the jalr bit-0 clear.
- ifu_stall = (state != IDLE) | ifu_jump_fire. It is combinational so the IFU cannot fetch in the same cycle it issues a jump.
- redirect_valid = (state == RESP). redirect_pc and redirect_misalign stay stable while redirect_valid is high and ready is low.

## Timing
- Reset values:
  - state = IDLE
  - redirect_valid = 0
  - redirect_pc = 0
  - redirect_misalign = 0
  - jump_cnt = 0
  - ifu_stall follows ifu_jump_fire
- Reset asserted in any state returns the block to IDLE on the next edge and drops any pending redirect. jump_cnt clears.
- Resolution latency: resolving exu_valid at cycle t gives redirect_valid high at t+1.
- Redirect fire at cycle u gives IDLE at u+1. ifu_stall is low at u+1 unless ifu_jump_fire is high at u+1.
- Minimum issue-to-redirect latency: jump_fire at t0, resolve at t0+1, redirect_valid at t0+2.
- Back-to-back jumps: a new ifu_jump_fire at u+1 is legal and re-enters WAIT at u+2.
- CSR inputs are sampled only on the resolving cycle. Later changes to mtvec or mepc do not alter a pending redirect_pc.

## Test plan
- Reset, then apply nothing → redirect_valid=0, jump_cnt=0, ifu_stall=0. Then pulse ifu_jump_fire → ifu_stall=1 in the same cycle and held afterwards.
- Jump fire, then exu_valid with exu_branch=1, exu_br_taken=1, exu_pc=0x3000_0010, exu_imm=0xFFFF_FFF0 → next cycle redirect_valid=1, redirect_pc=0x3000_0000, misalign=0. Repeat with taken=0 → redirect_pc=0x3000_0014.
- jalr with exu_rs1=0x8000_0003, exu_imm=0 → redirect_pc=0x8000_0002, redirect_misalign=1.
- ecall resolve with csr_mtvec=0x8000_0100, then change mtvec and hold redirect_ready=0 for 5 cycles → redirect_pc stays 0x8000_0100 and valid stays high. Assert ready → IDLE next cycle, jump_cnt=1.
- In WAIT, send 3 exu_valid beats with no class bit, then mret with csr_mepc=0x3000_0200 → only the mret resolves, redirect_pc=0x3000_0200. An ifu_jump_fire injected during RESP is ignored.
- Reset asserted in RESP with redirect_ready=0 → next cycle redirect_valid=0, state IDLE, jump_cnt=0. Preload jump_cnt=0xFFFF_FFFF and complete one redirect → jump_cnt=0.
